serial_adder: RTL and testbench

//  Bit-serial N-bit adder: one 1-bit full-adder cell (x,y,z -> s,c) reused once
//  per clock, LSB first, with a registered carry fed back as the next z input.

---
 rtl/serial_adder.sv | 125 ++++++++++++
 tb/tb_serial_adder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, LSB first, one full-adder cell per clock
// Optional SERIAL_ADDER_SUB_EN adds a latched `sub` input for A - B.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  // Subtraction folds into the load: B is stored inverted and the carry starts at 1.
  always_comb begin
    b_load     = b;
    carry_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_load     = ~b;
      carry_load = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    s_bit   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    c_next  = (a_sh_q[0] & b_sh_q[0]) | (carry_q & a_sh_q[0]) | (carry_q & b_sh_q[0]);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b_load;
          carry_d = carry_load;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        res_d   = {s_bit, res_q[WIDTH-1:1]};
        carry_d = c_next;
        cnt_d   = cnt_q + CW'(1);
        // The final bit lands directly in sum so the result appears on DONE entry.
        if (cnt_q == LAST) begin
          sum_d   = {s_bit, res_q[WIDTH-1:1]};
          cout_d  = c_next;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder at WIDTH 8 and 16
// SERIAL_ADDER_SUB_EN enables the subtract port and its vectors.
module tb_serial_adder;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    int          acc;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        rst_seen = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  logic        start8, cin8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        start16, cin16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;
`ifdef SERIAL_ADDER_SUB_EN
  logic        sub8, sub16;
`endif

  exp_t        q [2][$];
  logic [15:0] held_s [2];
  logic        held_c [2];

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub16),
`endif
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst_n;
  end

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s w=%0d cyc=%0d actual=%0h expected=%0h", name, (k == 0) ? 8 : 16, cyc, act, exp);
    end
  endtask

  // Unsigned WIDTH-bit add; subtraction as A + ~B + 1.
  function automatic void model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                input logic cv, input logic sv,
                                output logic [15:0] s, output logic co);
    logic [16:0] mask, bb, full;
    mask = (17'd1 << w) - 17'd1;
    bb   = sv ? (~{1'b0, bv} & mask) : ({1'b0, bv} & mask);
    full = ({1'b0, av} & mask) + bb + (sv ? 17'd1 : {16'd0, cv});
    s    = full[15:0] & mask[15:0];
    co   = full[w];
  endfunction

  task automatic mon(input int k, input logic bz, input logic dn, input logic [15:0] sm, input logic co);
    exp_t e;
    if (!rst_seen) begin
      chk("reset_state", k, {45'd0, bz, dn, co, sm}, 64'd0);
      q[k].delete();
      held_s[k] = '0;
      held_c[k] = 1'b0;
      return;
    end
    if (dn) begin
      if (q[k].size() == 0) begin
        chk("unexpected_done", k, {63'd0, dn}, 64'd0);
      end else begin
        e = q[k].pop_front();
        chk("done_cycle", k, 64'(cyc), 64'(e.due));
        chk("sum", k, {48'd0, sm}, {48'd0, e.sum});
        chk("cout", k, {63'd0, co}, {63'd0, e.cout});
        held_s[k] = e.sum;
        held_c[k] = e.cout;
      end
    end else begin
      chk("held_result", k, {47'd0, co, sm}, {47'd0, held_c[k], held_s[k]});
      if (q[k].size() > 0 && cyc >= q[k][0].due) begin
        chk("missing_done", k, {63'd0, dn}, 64'd1);
        void'(q[k].pop_front());
      end else begin
        chk("busy", k, {63'd0, bz}, {63'd0, q[k].size() > 0});
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon(0, busy8, done8, {8'd0, sum8}, cout8);
      mon(1, busy16, done16, sum16, cout16);
    end
  end

  task automatic issue(input int w, input logic [15:0] av, input logic [15:0] bv, input logic cv, input logic sv);
    int   n;
    int   k;
    logic eff_sub;
    exp_t e;
    k = (w == 8) ? 0 : 1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (((k == 0) ? (busy8 | done8) : (busy16 | done16)) && n < 200);
    chk("idle_wait", k, {63'd0, (k == 0) ? (busy8 | done8) : (busy16 | done16)}, 64'd0);
    eff_sub = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    eff_sub = sv;
    if (k == 0) sub8 = sv; else sub16 = sv;
`endif
    if (k == 0) begin
      start8 = 1'b1; a8 = av[7:0]; b8 = bv[7:0]; cin8 = cv;
    end else begin
      start16 = 1'b1; a16 = av; b16 = bv; cin16 = cv;
    end
    @(posedge clk); #1;
    model(w, av, bv, cv, eff_sub, e.sum, e.cout);
    e.acc = cyc;
    e.due = cyc + w;
    q[k].push_back(e);
    // Operands wander after accept; the latched copy must be unaffected.
    if (k == 0) begin
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    end else begin
      start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = 1'b0; sub16 = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    issue(8, 16'h3C, 16'h5A, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 start8 = 1'b1; a8 = 8'h00; b8 = 8'h00;
    @(posedge clk);
    #1 start8 = 1'b0;
    issue(8, 16'hFF, 16'h01, 1'b0, 1'b0);
    issue(8, 16'hFF, 16'hFF, 1'b1, 1'b0);
    issue(8, 16'h00, 16'h00, 1'b0, 1'b0);

    issue(8, 16'h3C, 16'h5A, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(8, 16'h01, 16'h01, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    issue(8, 16'h10, 16'h01, 1'b0, 1'b1);
    issue(8, 16'h01, 16'h02, 1'b1, 1'b1);
    issue(8, 16'h55, 16'h55, 1'b0, 1'b1);
`endif

    for (int i = 0; i < 200; i++)
      issue(8, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    issue(16, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++)
      issue(16, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

    n = 0;
    while ((q[0].size() + q[1].size()) != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    chk("drain", 0, 64'(q[0].size() + q[1].size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
